// File: rtl/byte_parity_check.sv
// -----------------------------------------------------------------------------
// byte_parity_check
//
// Receiver-side checker for the byte parity link. On an accepted start it
// captures operand A, the received parity byte (A ^ B) and the expected
// operand B. It then recovers B one bit per cycle (LSB first) and builds a
// per-bit mismatch mask against the expected value. A one-cycle done pulse
// marks the results as final, together with parity_err (OR of the mask).
//
// Ports:
//   clk          rising-edge clock
//   rst_n        synchronous active-low reset
//   start        transaction request, honoured only in IDLE or DONE
//   byte_a       operand A            (captured on accepted start)
//   byte_parity  received parity A^B  (captured on accepted start)
//   byte_b_exp   expected operand B   (captured on accepted start)
//   byte_b_rec   recovered B, filled in bit by bit
//   err_mask     bit i set when recovered B[i] differs from expected B[i]
//   parity_err   OR of err_mask, updated on entry to DONE
//   busy         high while bits are being processed
//   done         one-cycle pulse, results final
//   err_count    saturating count of mismatching bits (PARITY_ERR_CNT_EN only)
//
// Build option:
//   PARITY_ERR_CNT_EN  adds the err_count port and its 8-bit counter.
// -----------------------------------------------------------------------------
module byte_parity_check #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] byte_a,
    input  logic [DATA_WIDTH-1:0] byte_parity,
    input  logic [DATA_WIDTH-1:0] byte_b_exp,
    output logic [DATA_WIDTH-1:0] byte_b_rec,
    output logic [DATA_WIDTH-1:0] err_mask,
    output logic                  parity_err,
    output logic                  busy,
`ifdef PARITY_ERR_CNT_EN
    output logic                  done,
    output logic [7:0]            err_count
`else
    output logic                  done
`endif
);

    localparam int IDX_W = $clog2(DATA_WIDTH);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CHECK = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    // Recovered B bit is A ^ parity; a mismatch is that bit differing from expected B.
    function automatic logic bit_mismatch(input logic a_bit, input logic p_bit, input logic b_bit);
        return a_bit ^ p_bit ^ b_bit;
    endfunction

    state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0] a_q, a_d;
    logic [DATA_WIDTH-1:0] p_q, p_d;
    logic [DATA_WIDTH-1:0] b_q, b_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [DATA_WIDTH-1:0] rec_q, rec_d;
    logic [DATA_WIDTH-1:0] mask_q, mask_d;
    logic                  perr_q, perr_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  bit_rec_s;
    logic                  bit_err_s;

    // Next-state, capture and per-bit result logic.
    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        p_d       = p_q;
        b_d       = b_q;
        idx_d     = idx_q;
        rec_d     = rec_q;
        mask_d    = mask_q;
        perr_d    = perr_q;
        bit_rec_s = a_q[idx_q] ^ p_q[idx_q];
        bit_err_s = bit_mismatch(a_q[idx_q], p_q[idx_q], b_q[idx_q]);

        case (state_q)
            // DONE accepts a new start exactly like IDLE, giving back-to-back operation.
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    a_d     = byte_a;
                    p_d     = byte_parity;
                    b_d     = byte_b_exp;
                    idx_d   = '0;
                    rec_d   = '0;
                    mask_d  = '0;
                    perr_d  = 1'b0;
                    state_d = ST_CHECK;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CHECK: begin
                rec_d[idx_q]  = bit_rec_s;
                mask_d[idx_q] = bit_err_s;
                // idx stops at the last bit instead of wrapping; it is reloaded on the next start.
                if (idx_q == IDX_LAST) begin
                    state_d = ST_DONE;
                    perr_d  = |mask_d;
                end else begin
                    idx_d   = idx_q + IDX_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d == ST_CHECK);
        done_d = (state_d == ST_DONE);
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            p_q     <= '0;
            b_q     <= '0;
            idx_q   <= '0;
            rec_q   <= '0;
            mask_q  <= '0;
            perr_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            p_q     <= p_d;
            b_q     <= b_d;
            idx_q   <= idx_d;
            rec_q   <= rec_d;
            mask_q  <= mask_d;
            perr_q  <= perr_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign byte_b_rec = rec_q;
    assign err_mask   = mask_q;
    assign parity_err = perr_q;
    assign busy       = busy_q;
    assign done       = done_q;

`ifdef PARITY_ERR_CNT_EN
    logic [7:0] cnt_q, cnt_d;

    // Mismatch counter: one step per bad bit while checking, saturating at 255.
    always_comb begin
        cnt_d = cnt_q;
        if ((state_q == ST_CHECK) && bit_err_s && (cnt_q != 8'hFF)) begin
            cnt_d = cnt_q + 8'd1;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Counter register; cleared only by reset, never by start.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= 8'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign err_count = cnt_q;
`endif

endmodule

// File: tb/tb_byte_parity_check.sv
// -----------------------------------------------------------------------------
// Testbench for byte_parity_check. A behavioural reference computes the
// expected recovered byte (A ^ parity), mismatch mask and mismatch count
// directly from each transaction's operands, and the bench checks the DUT's
// outputs cycle by cycle against those values and the documented timing.
// -----------------------------------------------------------------------------
module tb_byte_parity_check;

    localparam int DW = 8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [7:0] byte_a;
    logic [7:0] byte_parity;
    logic [7:0] byte_b_exp;
    logic [7:0] byte_b_rec;
    logic [7:0] err_mask;
    logic       parity_err;
    logic       busy;
    logic       done;
`ifdef PARITY_ERR_CNT_EN
    logic [7:0] err_count;
`endif

    int checks = 0;
    int errors = 0;
    int cnt_model = 0;

    always #5 clk = ~clk;

    byte_parity_check #(.DATA_WIDTH(DW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .byte_a     (byte_a),
        .byte_parity(byte_parity),
        .byte_b_exp (byte_b_exp),
        .byte_b_rec (byte_b_rec),
        .err_mask   (err_mask),
        .parity_err (parity_err),
        .busy       (busy),
`ifdef PARITY_ERR_CNT_EN
        .done       (done),
        .err_count  (err_count)
`else
        .done       (done)
`endif
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check_cnt(input string tag);
`ifdef PARITY_ERR_CNT_EN
        check_eq(tag, {24'd0, err_count}, cnt_model);
`endif
    endtask

    task automatic add_errors(input logic [7:0] em);
        cnt_model = cnt_model + $countones(em);
        if (cnt_model > 255) cnt_model = 255;
    endtask

    // One transaction from IDLE. inject>0 pulses a competing start (b_exp=0)
    // that many cycles into CHECK; it must be ignored.
    task automatic run_txn(input logic [7:0] a, input logic [7:0] p, input logic [7:0] b, input int inject);
        logic [7:0] er;
        logic [7:0] em;
        logic [7:0] low;
        er = a ^ p;
        em = er ^ b;
        byte_a = a; byte_parity = p; byte_b_exp = b; start = 1'b1;
        tick;                                   // accept edge
        start = 1'b0;
        byte_a = 8'($urandom); byte_parity = 8'($urandom); byte_b_exp = 8'($urandom);
        check_eq("busy_first", {31'd0, busy}, 32'd1);
        check_eq("rec_clear", {24'd0, byte_b_rec}, 32'd0);
        check_eq("mask_clear", {24'd0, err_mask}, 32'd0);
        check_eq("done_early", {31'd0, done}, 32'd0);
        for (int j = 1; j < DW; j++) begin
            if (j == inject) begin
                start = 1'b1;
                byte_b_exp = 8'h00;
            end
            tick;
            start = 1'b0;
            low = 8'((1 << j) - 1);
            check_eq("rec_partial", {24'd0, byte_b_rec}, {24'd0, er & low});
            check_eq("mask_partial", {24'd0, err_mask}, {24'd0, em & low});
            check_eq("busy_mid", {31'd0, busy}, 32'd1);
            check_eq("done_mid", {31'd0, done}, 32'd0);
        end
        tick;                                   // 9th edge counting the accept edge
        add_errors(em);
        check_eq("done_pulse", {31'd0, done}, 32'd1);
        check_eq("busy_done", {31'd0, busy}, 32'd0);
        check_eq("rec_final", {24'd0, byte_b_rec}, {24'd0, er});
        check_eq("mask_final", {24'd0, err_mask}, {24'd0, em});
        check_eq("perr_final", {31'd0, parity_err}, {31'd0, |em});
        check_cnt("cnt_final");
        tick;
        check_eq("done_drop", {31'd0, done}, 32'd0);
        check_eq("rec_hold", {24'd0, byte_b_rec}, {24'd0, er});
        check_eq("mask_hold", {24'd0, err_mask}, {24'd0, em});
        check_eq("perr_hold", {31'd0, parity_err}, {31'd0, |em});
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_rec"}, {24'd0, byte_b_rec}, 32'd0);
        check_eq({tag, "_mask"}, {24'd0, err_mask}, 32'd0);
        check_eq({tag, "_perr"}, {31'd0, parity_err}, 32'd0);
        check_eq({tag, "_busy"}, {31'd0, busy}, 32'd0);
        check_eq({tag, "_done"}, {31'd0, done}, 32'd0);
        check_cnt({tag, "_cnt"});
    endtask

    initial begin
        int done_seen;
        logic [7:0] a;
        logic [7:0] p;
        logic [7:0] b;

        rst_n = 1'b0; start = 1'b0;
        byte_a = 8'h00; byte_parity = 8'h00; byte_b_exp = 8'h00;
        tick; tick;
        cnt_model = 0;
        check_all_zero("reset");
        rst_n = 1'b1;
        tick;

        // Clean byte and single-bit error.
        run_txn(8'hA5, 8'hFF, 8'h5A, 0);
        run_txn(8'hA5, 8'hFF, 8'h5B, 0);

        // Competing start three cycles into CHECK must be ignored.
        run_txn(8'h3C, 8'h99, 8'hA5, 3);

        // Reset in the 4th cycle of CHECK abandons the transaction.
        byte_a = 8'hA5; byte_parity = 8'hFF; byte_b_exp = 8'h00; start = 1'b1;
        tick;
        start = 1'b0;
        tick; tick; tick;
        rst_n = 1'b0;
        tick;
        cnt_model = 0;
        check_all_zero("midreset");
        rst_n = 1'b1;
        done_seen = 0;
        for (int i = 0; i < 12; i++) begin
            tick;
            if (done) done_seen++;
        end
        check_eq("no_done_after_reset", done_seen, 32'd0);
        run_txn(8'hA5, 8'hFF, 8'h5A, 0);

        // Back-to-back: start held across DONE.
        byte_a = 8'h00; byte_parity = 8'hF0; byte_b_exp = 8'h0F; start = 1'b1;
        tick;
        for (int i = 0; i < DW; i++) tick;
        add_errors(8'hFF);
        check_eq("b2b_done1", {31'd0, done}, 32'd1);
        check_eq("b2b_mask1", {24'd0, err_mask}, 32'hFF);
        check_cnt("b2b_cnt1");
        tick;                                   // second accept, from DONE
        check_eq("b2b_restart", {31'd0, busy}, 32'd1);
        check_eq("b2b_done_gap", {31'd0, done}, 32'd0);
        start = 1'b0;
        for (int i = 0; i < DW; i++) tick;
        add_errors(8'hFF);
        check_eq("b2b_done2", {31'd0, done}, 32'd1);
        check_eq("b2b_mask2", {24'd0, err_mask}, 32'hFF);
        check_eq("b2b_perr2", {31'd0, parity_err}, 32'd1);
        check_eq("b2b_rec2", {24'd0, byte_b_rec}, 32'hF0);
        check_cnt("b2b_cnt2");
        tick;

        // Randomized transactions, some clean, some with sparse errors.
        for (int i = 0; i < 40; i++) begin
            a = 8'($urandom);
            p = 8'($urandom);
            b = a ^ p;
            if (i % 3 != 0) b = b ^ (8'($urandom) & 8'($urandom));
            run_txn(a, p, b, (i % 5 == 0) ? int'($urandom_range(1, 7)) : 0);
        end

        // Counter saturation: 32 all-wrong bytes, then one more.
        for (int i = 0; i < 32; i++) begin
            a = 8'($urandom);
            p = 8'($urandom);
            run_txn(a, p, ~(a ^ p), 0);
        end
`ifdef PARITY_ERR_CNT_EN
        check_eq("cnt_saturated", {24'd0, err_count}, 32'd255);
`endif
        run_txn(8'h12, 8'h34, 8'hFF, 0);
`ifdef PARITY_ERR_CNT_EN
        check_eq("cnt_stays_sat", {24'd0, err_count}, 32'd255);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
